// File: rtl/wrr_arbiter.sv
// Weighted round-robin / fixed-priority arbiter for N requesters.
// Produces a registered one-hot grant with its index; each weight sets a grant burst length.
module wrr_arbiter #(
  parameter int N  = 4,
  parameter int WW = 4,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic            mode,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_id
);

  logic [N-1:0]  grant_q, grant_d;
  logic          grant_valid_q, grant_valid_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [WW-1:0] credit_q, credit_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic          holder_req;
  logic          hold;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand_idx;
  int            cand;

  // A zero weight field still earns one grant cycle.
  function automatic logic [WW-1:0] eff_weight(input logic [N*WW-1:0] w,
                                               input logic [IW-1:0]   idx);
    logic [WW-1:0] f;
    f = w[int'(idx)*WW +: WW];
    return (f == '0) ? WW'(1) : f;
  endfunction

  always_comb begin
    grant_d       = '0;
    grant_valid_d = 1'b0;
    grant_id_d    = '0;
    credit_d      = credit_q;
    ptr_d         = ptr_q;
    win_found     = 1'b0;
    win_idx       = '0;
    cand          = 0;
    cand_idx      = '0;

    holder_req = grant_valid_q && req[grant_id_q];
    // Credit is forced to 0 in fixed-priority mode, so a 1->0 switch never holds.
    hold       = !mode && holder_req && (credit_q > WW'(1));

    // Fixed priority scans from index 0; round-robin scans from the slot after the pointer.
    for (int k = 0; k < N; k++) begin
      cand     = mode ? k : (int'(ptr_q) + 1 + k) % N;
      cand_idx = IW'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end

    if (hold) begin
      grant_d       = grant_q;
      grant_valid_d = 1'b1;
      grant_id_d    = grant_id_q;
      credit_d      = credit_q - WW'(1);
    end else if (win_found) begin
      grant_d[win_idx] = 1'b1;
      grant_valid_d    = 1'b1;
      grant_id_d       = win_idx;
      ptr_d            = win_idx;
      credit_d         = mode ? '0 : eff_weight(weight, win_idx);
    end else begin
      credit_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      credit_q      <= '0;
      ptr_q         <= IW'(N - 1);
    end else begin
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      credit_q      <= credit_d;
      ptr_q         <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule
